// File: rtl/debug_session_ctrl.sv
// Debug command sequencer: decodes UART command bytes, gates the CPU clock enable/reset,
// and hands a frame to the debugger TX after every halt, step or dump.
module debug_session_ctrl #(
    parameter logic [7:0]  CMD_RUN    = 8'h63,
    parameter logic [7:0]  CMD_STEP   = 8'h73,
    parameter logic [7:0]  CMD_DUMP   = 8'h64,
    parameter logic [7:0]  CMD_RESET  = 8'h72,
    parameter int unsigned MAX_CYCLES = 1000000,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TX_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [7:0]  r_data,
    input  logic        halt_in,
    input  logic        dataSent,
    output logic        cpu_enable,
    output logic        cpu_reset,
    output logic        send_signal,
    output logic        busy,
    output logic        halted,
    output logic        cmd_err,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STEP    = 3'd2,
        CRST    = 3'd3,
        SEND    = 3'd4,
        WAIT_LO = 3'd5,
        WAIT_HI = 3'd6
    } state_t;

    localparam logic [31:0] RUN_LAST = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TX_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_cycle_count;
    logic        r_cpu_enable;
    logic        r_cpu_reset;
    logic        r_send_signal;
    logic        r_busy;
    logic        r_halted;
    logic        r_cmd_err;

    state_t      w_next;
    logic        w_err;
    logic        w_enabled;

    // RUN/STEP are exactly the states in which cpu_enable is high
    assign w_enabled = (r_state == RUN) || (r_state == STEP);

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_done) begin
                    case (r_data)
                        CMD_RUN:   if (r_halted) w_err = 1'b1; else w_next = RUN;
                        CMD_STEP:  if (r_halted) w_err = 1'b1; else w_next = STEP;
                        CMD_DUMP:  w_next = SEND;
                        CMD_RESET: w_next = CRST;
                        default:   w_err = 1'b1;
                    endcase
                end
            end
            RUN: begin
                if (halt_in || (r_cnt == RUN_LAST)) w_next = SEND;
            end
            STEP:    w_next = SEND;
            CRST: begin
                if (r_cnt == RST_LAST) w_next = IDLE;
            end
            SEND: begin
                if (dataSent) w_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!dataSent) begin
                    w_next = WAIT_HI;
                end else if (r_cnt == TO_LAST) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            WAIT_HI: begin
                if (dataSent) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rx_done && (r_state != IDLE)) w_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cycle_count <= '0;
            r_cpu_enable  <= 1'b0;
            r_cpu_reset   <= 1'b0;
            r_send_signal <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            // Shared per-state counter: restarts on every state change, saturates otherwise
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_next == CRST) begin
                r_cycle_count <= '0;
                r_halted      <= 1'b0;
            end else if (w_enabled) begin
                if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
                if (halt_in) r_halted <= 1'b1;
            end

            r_cpu_enable  <= (w_next == RUN) || (w_next == STEP);
            r_cpu_reset   <= (w_next == CRST);
            r_send_signal <= (r_state == SEND) && dataSent;
            r_busy        <= (w_next != IDLE);
            r_cmd_err     <= w_err;
        end
    end

    assign cpu_enable  = r_cpu_enable;
    assign cpu_reset   = r_cpu_reset;
    assign send_signal = r_send_signal;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign cmd_err     = r_cmd_err;
    assign cycle_count = r_cycle_count;

endmodule
